// File: rtl/mega_ram_mp.sv
// mega_ram_mp
// Shared single-array data RAM for several bus masters (CPU, DMA, debug).
// A round-robin arbiter grants at most one channel per clock with a
// combinational ack. Writes honour byte-lane enables. Reads return one clock
// after the grant edge, together with a one-cycle valid strobe. A combined
// write+read returns the merged post-write word. Out-of-range addresses are
// still acknowledged: their writes are dropped and their reads return zero.
module mega_ram_mp #(
    parameter int    CHANNELS       = 2,
    parameter int    ADDR_BUS_WIDTH = 13,
    parameter int    ADDR_RAM_DEPTH = 2 ** ADDR_BUS_WIDTH,
    parameter int    DATA_BUS_WIDTH = 8,
    parameter string RAM_PATH       = ""
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [CHANNELS-1:0]                       cs,
    input  logic [CHANNELS-1:0]                       we,
    input  logic [CHANNELS-1:0]                       re,
    input  logic [CHANNELS*ADDR_BUS_WIDTH-1:0]        a,
    input  logic [CHANNELS*(DATA_BUS_WIDTH/8)-1:0]    be,
    input  logic [CHANNELS*DATA_BUS_WIDTH-1:0]        d_in,
    output logic [CHANNELS-1:0]                       ack,
    output logic [CHANNELS-1:0]                       d_valid,
    output logic [CHANNELS*DATA_BUS_WIDTH-1:0]        d_out
);

    localparam int BE = DATA_BUS_WIDTH / 8;
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW = (ADDR_RAM_DEPTH > 1) ? $clog2(ADDR_RAM_DEPTH) : 1;
    localparam logic [PW:0]             CH_CNT  = (PW + 1)'(CHANNELS);
    localparam logic [PW-1:0]           CH_LAST = PW'(CHANNELS - 1);
    localparam logic [ADDR_BUS_WIDTH:0] DEPTH_L = (ADDR_BUS_WIDTH + 1)'(ADDR_RAM_DEPTH);

    logic [DATA_BUS_WIDTH-1:0] mem [ADDR_RAM_DEPTH];

    logic [CHANNELS-1:0]             req;
    logic [PW-1:0]                   ptr_q, ptr_d;
    logic [PW:0]                     cand;
    logic                            grant_valid;
    logic [PW-1:0]                   grant_idx;
    logic                            sel_we, sel_re;
    logic [ADDR_BUS_WIDTH-1:0]       sel_a;
    logic [BE-1:0]                   sel_be;
    logic [DATA_BUS_WIDTH-1:0]       sel_d;
    logic                            in_range;
    logic [IW-1:0]                   mem_idx;
    logic [DATA_BUS_WIDTH-1:0]       mem_word, merged_word, rd_word;
    logic [CHANNELS-1:0]             d_valid_q, d_valid_d;
    logic [CHANNELS*DATA_BUS_WIDTH-1:0] d_out_q, d_out_d;

    // Round-robin search from ptr upward with wrap; reset suppresses every grant.
    always_comb begin
        req         = cs & (we | re);
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cand = {1'b0, ptr_q} + (PW + 1)'(i);
                if (cand >= CH_CNT) begin
                    cand = cand - CH_CNT;
                end
                if (!grant_valid && req[cand[PW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[PW-1:0];
                end
            end
        end
    end

    // One-hot ack and the pointer advancing past the granted channel.
    always_comb begin
        ack   = '0;
        ptr_d = ptr_q;
        if (grant_valid) begin
            ack[grant_idx] = 1'b1;
            ptr_d = (grant_idx == CH_LAST) ? '0 : grant_idx + PW'(1);
        end
    end

    // Route the granted channel's request fields onto the single RAM port.
    always_comb begin
        sel_we   = we[grant_idx];
        sel_re   = re[grant_idx];
        sel_a    = a[grant_idx*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
        sel_be   = be[grant_idx*BE +: BE];
        sel_d    = d_in[grant_idx*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
        in_range = ({1'b0, sel_a} < DEPTH_L);
        mem_idx  = sel_a[IW-1:0];
    end

    // Byte-lane merge gives write-first semantics for a combined write+read.
    always_comb begin
        mem_word    = mem[mem_idx];
        merged_word = mem_word;
        for (int j = 0; j < BE; j++) begin
            if (sel_be[j]) begin
                merged_word[j*8 +: 8] = sel_d[j*8 +: 8];
            end
        end
        rd_word = '0;
        if (in_range) begin
            rd_word = sel_we ? merged_word : mem_word;
        end
    end

    // Read return: only the granted reader gets data; everyone else sees zero.
    always_comb begin
        d_valid_d = '0;
        d_out_d   = '0;
        if (grant_valid && sel_re) begin
            d_valid_d[grant_idx] = 1'b1;
            d_out_d[grant_idx*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] = rd_word;
        end
    end

    // RAM array write; out-of-range writes are acknowledged but dropped.
    always_ff @(posedge clk) begin
        if (grant_valid && sel_we && in_range) begin
            mem[mem_idx] <= merged_word;
        end
    end

    // Arbiter pointer and read-return registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            d_valid_q <= '0;
            d_out_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            d_valid_q <= d_valid_d;
            d_out_q   <= d_out_d;
        end
    end

    assign d_valid = d_valid_q;
    assign d_out   = d_out_q;

endmodule

// File: tb/tb_mega_ram_mp.sv
// tb_mega_ram_mp
// Bench for a 3-channel, 16-bit, 4096-word instance addressed with 13 bits.
// A directed vector table covers byte-lane merge, write-first, out-of-range
// access and arbitration order. A short reset sequence follows. Then random
// masters are checked against an array/round-robin reference model.
module tb_mega_ram_mp;

    localparam int CH    = 3;
    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic [CH-1:0]      cs;
        logic [CH-1:0]      we;
        logic [CH-1:0]      re;
        logic [CH*AW-1:0]   a;
        logic [CH*2-1:0]    be;
        logic [CH*DW-1:0]   din;
        logic [CH-1:0]      eAck;
        logic [CH-1:0]      eVal;
        logic [CH*DW-1:0]   eOut;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [CH-1:0]      cs, we, re;
    logic [CH*AW-1:0]   a;
    logic [CH*2-1:0]    be;
    logic [CH*DW-1:0]   dIn;
    logic [CH-1:0]      ack, dValid;
    logic [CH*DW-1:0]   dOut;

    int checks   = 0;
    int failures = 0;

    mega_ram_mp #(
        .CHANNELS       (CH),
        .ADDR_BUS_WIDTH (AW),
        .ADDR_RAM_DEPTH (DEPTH),
        .DATA_BUS_WIDTH (DW),
        .RAM_PATH       ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .re      (re),
        .a       (a),
        .be      (be),
        .d_in    (dIn),
        .ack     (ack),
        .d_valid (dValid),
        .d_out   (dOut)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t oneCh(input int ch, input bit w, input bit r,
                                   input logic [AW-1:0] addr, input logic [1:0] b,
                                   input logic [DW-1:0] d, input logic [CH-1:0] ea,
                                   input logic [CH-1:0] ev, input logic [CH*DW-1:0] eo);
        vec_t v;
        v = '0;
        v.cs[ch] = 1'b1;
        v.we[ch] = w;
        v.re[ch] = r;
        v.a[ch*AW +: AW] = addr;
        v.be[ch*2 +: 2] = b;
        v.din[ch*DW +: DW] = d;
        v.eAck = ea;
        v.eVal = ev;
        v.eOut = eo;
        return v;
    endfunction

    function automatic vec_t idleRow(input logic [CH-1:0] ev, input logic [CH*DW-1:0] eo);
        vec_t v;
        v = '0;
        v.eVal = ev;
        v.eOut = eo;
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        cs  = v.cs;
        we  = v.we;
        re  = v.re;
        a   = v.a;
        be  = v.be;
        dIn = v.din;
    endtask

    task automatic checkOutput(input string tag, input logic [CH-1:0] eAck,
                               input logic [CH-1:0] eVal, input logic [CH*DW-1:0] eOut,
                               input bit ackOnly);
        checks++;
        if (ack !== eAck) begin
            failures++;
            $display("[TB] FAIL %s ack: got %b want %b", tag, ack, eAck);
        end
        if (!ackOnly) begin
            checks++;
            if (dValid !== eVal) begin
                failures++;
                $display("[TB] FAIL %s d_valid: got %b want %b", tag, dValid, eVal);
            end
            checks++;
            if (dOut !== eOut) begin
                failures++;
                $display("[TB] FAIL %s d_out: got %h want %h", tag, dOut, eOut);
            end
        end
    endtask

    vec_t rows [17];

    // Random-phase master state and reference model.
    bit               pend [CH];
    bit               pW   [CH];
    bit               pR   [CH];
    logic [AW-1:0]    pA   [CH];
    logic [1:0]       pB   [CH];
    logic [DW-1:0]    pD   [CH];
    logic [DW-1:0]    modelMem [int];
    logic [AW-1:0]    pool [5];
    int               rrPtr;
    logic [CH-1:0]    expAck, expVal;
    logic [CH*DW-1:0] expOut;

    initial begin
        rows[0]  = oneCh(0, 1, 0, 13'h020, 2'b11, 16'h1234, 3'b001, 3'b000, '0);
        rows[1]  = oneCh(0, 1, 0, 13'h020, 2'b01, 16'hBEEF, 3'b001, 3'b000, '0);
        rows[2]  = oneCh(0, 0, 1, 13'h020, 2'b00, 16'h0000, 3'b001, 3'b000, '0);
        rows[3]  = oneCh(1, 1, 0, 13'h800, 2'b11, 16'h7777, 3'b010, 3'b001, 48'h0000_0000_12EF);
        rows[4]  = oneCh(1, 1, 1, 13'h005, 2'b11, 16'h005A, 3'b010, 3'b000, '0);
        rows[5]  = oneCh(2, 0, 1, 13'h1800, 2'b00, 16'h0000, 3'b100, 3'b010, 48'h0000_005A_0000);
        rows[6]  = oneCh(2, 1, 0, 13'h1800, 2'b11, 16'hFFFF, 3'b100, 3'b100, '0);
        rows[7]  = oneCh(0, 0, 1, 13'h800, 2'b00, 16'h0000, 3'b001, 3'b000, '0);
        rows[8]  = vec_t'(oneCh(0, 0, 1, 13'h020, 2'b00, 16'h0, 3'b010, 3'b001, 48'h0000_0000_7777)
                        | oneCh(1, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)
                        | oneCh(2, 0, 1, 13'h800, 2'b00, 16'h0, '0, '0, '0));
        rows[9]  = vec_t'(oneCh(0, 0, 1, 13'h020, 2'b00, 16'h0, 3'b100, 3'b010, 48'h0000_005A_0000)
                        | oneCh(2, 0, 1, 13'h800, 2'b00, 16'h0, '0, '0, '0));
        rows[10] = oneCh(0, 0, 1, 13'h020, 2'b00, 16'h0, 3'b001, 3'b100, 48'h7777_0000_0000);
        rows[11] = idleRow(3'b001, 48'h0000_0000_12EF);
        rows[12] = idleRow(3'b000, '0);
        rows[13] = oneCh(1, 0, 1, 13'h005, 2'b00, 16'h0, 3'b010, 3'b000, '0);
        rows[14] = oneCh(1, 0, 1, 13'h020, 2'b00, 16'h0, 3'b010, 3'b010, 48'h0000_005A_0000);
        rows[15] = idleRow(3'b010, 48'h0000_12EF_0000);
        rows[16] = idleRow(3'b000, '0);

        // Reset with all channels requesting: nothing may be granted.
        rst = 1'b1;
        applyStimulus(vec_t'(oneCh(0, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)
                           | oneCh(1, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)
                           | oneCh(2, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)));
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset", 3'b000, 3'b000, '0, 1'b0);
        nextCycle();
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), rows[i].eAck, rows[i].eVal, rows[i].eOut, 1'b0);
            nextCycle();
        end

        // Read granted, then reset on the following edge.
        applyStimulus(oneCh(1, 0, 1, 13'h020, 2'b00, 16'h0, '0, '0, '0));
        @(negedge clk);
        checkOutput("rst_pre", 3'b010, 3'b000, '0, 1'b0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(vec_t'(oneCh(0, 0, 1, 13'h020, 2'b00, 16'h0, '0, '0, '0)
                           | oneCh(1, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)
                           | oneCh(2, 0, 1, 13'h800, 2'b00, 16'h0, '0, '0, '0)));
        @(negedge clk);
        checkOutput("rst_ack", 3'b000, 3'b000, '0, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("rst_hold", 3'b000, 3'b000, '0, 1'b0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ptr0", 3'b001, 3'b000, '0, 1'b0);
        nextCycle();
        applyStimulus(vec_t'(oneCh(1, 0, 1, 13'h005, 2'b00, 16'h0, '0, '0, '0)
                           | oneCh(2, 0, 1, 13'h800, 2'b00, 16'h0, '0, '0, '0)));
        @(negedge clk);
        checkOutput("rst_keep0", 3'b010, 3'b001, 48'h0000_0000_12EF, 1'b0);
        nextCycle();
        applyStimulus(oneCh(2, 0, 1, 13'h800, 2'b00, 16'h0, '0, '0, '0));
        @(negedge clk);
        checkOutput("rst_keep1", 3'b100, 3'b010, 48'h0000_005A_0000, 1'b0);
        nextCycle();
        applyStimulus(idleRow('0, '0));
        @(negedge clk);
        checkOutput("rst_keep2", 3'b000, 3'b100, 48'h7777_0000_0000, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("rst_idle", 3'b000, 3'b000, '0, 1'b0);
        nextCycle();

        // Randomized masters against the reference model.
        modelMem[32'h020] = 16'h12EF;
        modelMem[32'h005] = 16'h005A;
        modelMem[32'h800] = 16'h7777;
        pool[0] = 13'h020;
        pool[1] = 13'h005;
        pool[2] = 13'h800;
        pool[3] = 13'h1800;
        pool[4] = 13'h1FFF;
        rrPtr  = 0;
        expVal = '0;
        expOut = '0;
        for (int k = 0; k < CH; k++) pend[k] = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            bit doReset;
            int g;
            doReset = ($urandom_range(0, 39) == 0);
            rst = doReset;
            for (int k = 0; k < CH; k++) begin
                if (!pend[k] && $urandom_range(0, 9) < 6) begin
                    pend[k] = 1'b1;
                    pW[k]   = 1'($urandom_range(0, 1));
                    pR[k]   = pW[k] ? 1'($urandom_range(0, 1)) : 1'b1;
                    pA[k]   = pool[$urandom_range(0, 4)];
                    pB[k]   = 2'($urandom_range(0, 3));
                    pD[k]   = 16'($urandom);
                end
                if (pend[k]) begin
                    cs[k] = 1'b1;
                    we[k] = pW[k];
                    re[k] = pR[k];
                    a[k*AW +: AW]   = pA[k];
                    be[k*2 +: 2]    = pB[k];
                    dIn[k*DW +: DW] = pD[k];
                end else begin
                    if ($urandom_range(0, 1) == 0) begin
                        cs[k] = 1'b0;
                        we[k] = 1'($urandom_range(0, 1));
                        re[k] = 1'($urandom_range(0, 1));
                    end else begin
                        cs[k] = 1'b1;
                        we[k] = 1'b0;
                        re[k] = 1'b0;
                    end
                    a[k*AW +: AW]   = 13'($urandom);
                    be[k*2 +: 2]    = 2'($urandom);
                    dIn[k*DW +: DW] = 16'($urandom);
                end
            end
            @(negedge clk);
            g = -1;
            expAck = '0;
            if (!doReset) begin
                for (int i = 0; i < CH; i++) begin
                    int k;
                    k = (rrPtr + i) % CH;
                    if (g < 0 && pend[k]) g = k;
                end
            end
            if (g >= 0) expAck[g] = 1'b1;
            checkOutput("rand", expAck, expVal, expOut, 1'b0);
            expVal = '0;
            expOut = '0;
            if (doReset) begin
                rrPtr = 0;
            end else if (g >= 0) begin
                int key;
                bit inR;
                key = int'(pA[g]);
                inR = (key < DEPTH);
                if (pW[g] && inR) begin
                    logic [DW-1:0] w;
                    w = modelMem[key];
                    for (int j = 0; j < 2; j++) begin
                        if (pB[g][j]) w[j*8 +: 8] = pD[g][j*8 +: 8];
                    end
                    modelMem[key] = w;
                end
                if (pR[g]) begin
                    expVal[g] = 1'b1;
                    expOut[g*DW +: DW] = inR ? modelMem[key] : 16'h0000;
                end
                pend[g] = 1'b0;
                rrPtr = (g + 1) % CH;
            end
            nextCycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
